// File: rtl/ecs_uart_cmd_proc_pkg.sv
// ---------------------------------------------------------------------------
// ecs_uart_cmd_proc_pkg
// Shared constants for the UART command processor: frame/reply header bytes,
// command codes, reply status codes, FSM state encoding and the frame
// validation priority function.
// ---------------------------------------------------------------------------
package ecs_uart_cmd_proc_pkg;

  // Frame / reply header bytes
  localparam logic [7:0] RX_HDR   = 8'hA5;
  localparam logic [7:0] TX_HDR   = 8'h5A;

  // Command codes (frame byte 3)
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] CMD_PING = 8'h03;

  // Reply status codes (reply byte 2)
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_CSUM  = 8'h01;
  localparam logic [7:0] ST_ADDR  = 8'h03;
  localparam logic [7:0] ST_CMD   = 8'h04;

  // Highest valid register address in the 4-byte control bank
  localparam logic [7:0] MAX_ADDR = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  // Status for a frame whose header is already known to be good.
  // Checksum errors win over address errors, which win over command errors.
  function automatic logic [7:0] frame_status(
    input logic [7:0] sum_calc,
    input logic [7:0] sum_rx,
    input logic [7:0] addr,
    input logic [7:0] cmd
  );
    logic [7:0] st;
    if (sum_calc != sum_rx)
      st = ST_CSUM;
    else if (addr > MAX_ADDR)
      st = ST_ADDR;
    else if ((cmd != CMD_WR) && (cmd != CMD_RD) && (cmd != CMD_PING))
      st = ST_CMD;
    else
      st = ST_OK;
    return st;
  endfunction

endpackage

// File: rtl/ecs_uart_cmd_proc_sum8.sv
// ---------------------------------------------------------------------------
// ecs_sum8
// Combinational 4-input modulo-256 adder used for frame and reply checksums.
// Ports:
//   i_a..i_d  in  8  addends (tie unused inputs to 0)
//   o_sum     out 8  (i_a + i_b + i_c + i_d) mod 256, carry discarded
// ---------------------------------------------------------------------------
module ecs_sum8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [7:0] i_c,
  input  logic [7:0] i_d,
  output logic [7:0] o_sum
);

  // 8-bit context drops the carries naturally
  assign o_sum = i_a + i_b + i_c + i_d;

endmodule

// File: rtl/ecs_uart_cmd_proc.sv
// ---------------------------------------------------------------------------
// ecs_uart_cmd_proc
// Command processor behind the UART receiver. On each rising edge of rx_rdy
// it latches a 5-byte frame (HDR ADDR CMD DATA SUM), validates it, executes
// WR/RD/PING against a 4-byte control register bank and produces a 4-byte
// reply (5A STATUS DATA SUM) with a one-cycle tx_en. After a reply the block
// stays busy for TX_GAP_CYC cycles (counted from tx_en) so the UART can shift
// the reply out.
// Ports:
//   clk_25m        in   1   system clock
//   rst            in   1   asynchronous active-high reset
//   rx_rdy         in   1   frame ready from UART, rising edge used
//   rx_b1..rx_b5   in   8   header, address, command, data, checksum
//   tx_b1..tx_b4   out  8   reply bytes, held until the next reply
//   tx_en          out  1   one-cycle reply strobe
//   ctrl_out       out  32  register bank, reg n = bits [8n+7:8n]
//   wr_stb         out  1   one-cycle pulse with each ctrl_out write
//   frame_err      out  1   one-cycle pulse per rejected/dropped frame
//   err_cnt        out  8   saturating rejected/dropped frame count
//   busy           out  1   high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module ecs_uart_cmd_proc
  import ecs_uart_cmd_proc_pkg::*;
#(
  parameter int          TX_GAP_CYC = 8700,
  parameter logic [31:0] CTRL_RST   = 32'h0,
  parameter logic [7:0]  VERSION    = 8'h10
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_b1,
  input  logic [7:0]  rx_b2,
  input  logic [7:0]  rx_b3,
  input  logic [7:0]  rx_b4,
  input  logic [7:0]  rx_b5,
  output logic [7:0]  tx_b1,
  output logic [7:0]  tx_b2,
  output logic [7:0]  tx_b3,
  output logic [7:0]  tx_b4,
  output logic        tx_en,
  output logic [31:0] ctrl_out,
  output logic        wr_stb,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  // Counter must hold TX_GAP_CYC-1
  localparam int GAP_W = (TX_GAP_CYC > 2) ? $clog2(TX_GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP_CYC - 1);

  state_e           r_state;
  logic             r_rdy_q;
  logic [7:0]       r_hdr;
  logic [7:0]       r_addr;
  logic [7:0]       r_cmd;
  logic [7:0]       r_data;
  logic [7:0]       r_sum;
  logic [7:0]       r_status;
  logic [GAP_W-1:0] r_gap_cnt;

  logic             w_start;
  logic [7:0]       w_rx_sum;
  logic [7:0]       w_chk_status;
  logic             w_hdr_bad;
  logic             w_drop;
  logic             w_chk_err;
  logic             w_err_evt;
  logic [7:0]       w_rd_byte;
  logic [7:0]       w_reply_data;
  logic [7:0]       w_tx_sum;
  logic             w_do_write;

  // Rising-edge detect: a level held high never re-triggers
  assign w_start = rx_rdy & ~r_rdy_q;

  ecs_sum8 u_rx_sum (
    .i_a   (r_hdr),
    .i_b   (r_addr),
    .i_c   (r_cmd),
    .i_d   (r_data),
    .o_sum (w_rx_sum)
  );

  assign w_hdr_bad    = (r_hdr != RX_HDR);
  assign w_chk_status = frame_status(w_rx_sum, r_sum, r_addr, r_cmd);

  // A new edge while not idle is discarded; a bad frame is rejected in CHECK.
  // These cannot coincide for one frame but are merged into one error event.
  assign w_drop    = w_start & (r_state != S_IDLE);
  assign w_chk_err = (r_state == S_CHECK) & (w_hdr_bad | (w_chk_status != ST_OK));
  assign w_err_evt = w_drop | w_chk_err;

  // Only the low two address bits matter once the address has been validated
  assign w_rd_byte  = ctrl_out[{r_addr[1:0], 3'b000} +: 8];
  assign w_do_write = (r_status == ST_OK) && (r_cmd == CMD_WR);

  always_comb begin
    w_reply_data = 8'h00;
    if (r_status == ST_OK) begin
      case (r_cmd)
        CMD_WR:   w_reply_data = r_data;
        CMD_RD:   w_reply_data = w_rd_byte;  // RD never writes, so this is the post-update value
        CMD_PING: w_reply_data = VERSION;
        default:  w_reply_data = 8'h00;
      endcase
    end
  end

  ecs_sum8 u_tx_sum (
    .i_a   (TX_HDR),
    .i_b   (r_status),
    .i_c   (w_reply_data),
    .i_d   (8'h00),
    .o_sum (w_tx_sum)
  );

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rdy_q   <= 1'b0;
      r_hdr     <= 8'h00;
      r_addr    <= 8'h00;
      r_cmd     <= 8'h00;
      r_data    <= 8'h00;
      r_sum     <= 8'h00;
      r_status  <= ST_OK;
      r_gap_cnt <= '0;
      tx_b1     <= 8'h00;
      tx_b2     <= 8'h00;
      tx_b3     <= 8'h00;
      tx_b4     <= 8'h00;
      tx_en     <= 1'b0;
      ctrl_out  <= CTRL_RST;
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      r_rdy_q   <= rx_rdy;
      tx_en     <= 1'b0;
      wr_stb    <= 1'b0;
      frame_err <= w_err_evt;
      if (w_err_evt && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_hdr   <= rx_b1;
            r_addr  <= rx_b2;
            r_cmd   <= rx_b3;
            r_data  <= rx_b4;
            r_sum   <= rx_b5;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_status <= w_chk_status;
          // Bad header: silent drop, no reply at all
          r_state  <= w_hdr_bad ? S_IDLE : S_EXEC;
        end
        S_EXEC: begin
          if (w_do_write) begin
            ctrl_out[{r_addr[1:0], 3'b000} +: 8] <= r_data;
            wr_stb <= 1'b1;
          end
          tx_b1     <= TX_HDR;
          tx_b2     <= r_status;
          tx_b3     <= w_reply_data;
          tx_b4     <= w_tx_sum;
          tx_en     <= 1'b1;
          // Gap is counted from the tx_en cycle onwards
          r_gap_cnt <= GAP_LOAD;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == '0)
            r_state <= S_IDLE;
          else
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecs_uart_cmd_proc.sv
module tb_ecs_uart_cmd_proc;

  localparam int GAP = 16;

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_b1 = 8'h00, rx_b2 = 8'h00, rx_b3 = 8'h00, rx_b4 = 8'h00, rx_b5 = 8'h00;
  logic [7:0]  tx_b1, tx_b2, tx_b3, tx_b4;
  logic        tx_en, wr_stb, frame_err, busy;
  logic [31:0] ctrl_out;
  logic [7:0]  err_cnt;

  always #20 clk_25m = ~clk_25m;

  ecs_uart_cmd_proc #(
    .TX_GAP_CYC (GAP),
    .CTRL_RST   (32'h0),
    .VERSION    (8'h10)
  ) dut (
    .clk_25m   (clk_25m),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_b1     (rx_b1),
    .rx_b2     (rx_b2),
    .rx_b3     (rx_b3),
    .rx_b4     (rx_b4),
    .rx_b5     (rx_b5),
    .tx_b1     (tx_b1),
    .tx_b2     (tx_b2),
    .tx_b3     (tx_b3),
    .tx_b4     (tx_b4),
    .tx_en     (tx_en),
    .ctrl_out  (ctrl_out),
    .wr_stb    (wr_stb),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: register bytes and saturating error count
  logic [7:0] m_regs [4];
  int         m_err;

  // Observations of one frame window (k = cycles after the start edge)
  int          cap_tx_cnt, cap_tx_k, cap_wr_cnt, cap_wr_k, cap_ferr_cnt, cap_ferr_k, cap_busy_last;
  logic [31:0] cap_tx;

  function automatic logic [31:0] model_ctrl();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_err = 0;
  endfunction

  function automatic void model_err();
    m_err = (m_err >= 255) ? 255 : m_err + 1;
  endfunction

  // Frame semantics from the rules: drop / status / reply data / write flag
  function automatic void model_frame(input logic [7:0] b1, b2, b3, b4, b5,
                                      output bit drop, output logic [7:0] st,
                                      output logic [7:0] dat, output bit wr);
    int s;
    s = (int'(b1) + int'(b2) + int'(b3) + int'(b4)) % 256;
    drop = 0; st = 8'h00; dat = 8'h00; wr = 0;
    if (b1 != 8'hA5) begin
      drop = 1;
      model_err();
      return;
    end
    if (s != int'(b5))             st = 8'h01;
    else if (b2 > 8'd3)            st = 8'h03;
    else if (b3 < 8'd1 || b3 > 8'd3) st = 8'h04;
    if (st != 8'h00) begin
      model_err();
      return;
    end
    case (b3)
      8'd1: begin m_regs[b2[1:0]] = b4; dat = b4; wr = 1; end
      8'd2: dat = m_regs[b2[1:0]];
      default: dat = 8'h10;
    endcase
  endfunction

  function automatic logic [31:0] model_reply(input logic [7:0] st, input logic [7:0] dat);
    logic [7:0] s;
    s = 8'((32'h5A + 32'(st) + 32'(dat)) % 256);
    return {8'h5A, st, dat, s};
  endfunction

  // Drive one frame and observe 24 cycles. inj_k: raise rx_rdy again after
  // observation k; rst_k: pulse reset after observation k; hold: keep rx_rdy high.
  task automatic run_frame(input logic [7:0] b1, b2, b3, b4, b5,
                           input int inj_k, input int rst_k, input bit hold);
    int t;
    cap_tx_cnt = 0; cap_tx_k = -1; cap_wr_cnt = 0; cap_wr_k = -1;
    cap_ferr_cnt = 0; cap_ferr_k = -1; cap_busy_last = -1; cap_tx = 32'h0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(posedge clk_25m); #1; t++;
    end
    if (busy !== 1'b0) begin
      n_checks++; n_errors++;
      $display("FAIL idle_wait: busy=%b required 0", busy);
    end
    @(negedge clk_25m);
    rx_b1 = b1; rx_b2 = b2; rx_b3 = b3; rx_b4 = b4; rx_b5 = b5;
    rx_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk_25m); #1;
      if (tx_en === 1'b1) begin
        if (cap_tx_cnt == 0) begin cap_tx_k = k; cap_tx = {tx_b1, tx_b2, tx_b3, tx_b4}; end
        cap_tx_cnt++;
      end
      if (wr_stb === 1'b1)    begin cap_wr_cnt++;   cap_wr_k = k;   end
      if (frame_err === 1'b1) begin cap_ferr_cnt++; cap_ferr_k = k; end
      if (busy === 1'b1) cap_busy_last = k;
      if (k == 0 && !hold) rx_rdy = 1'b0;
      if (k == inj_k) rx_rdy = 1'b1;
      if (k == inj_k + 1 && !hold) rx_rdy = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_25m);
    #1;
    n_checks++;
    if ({tx_b1, tx_b2, tx_b3, tx_b4, tx_en, wr_stb, frame_err, err_cnt, busy} !== 45'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got tx=%h%h%h%h en=%b wr=%b ferr=%b cnt=%h busy=%b, required all 0",
               tx_b1, tx_b2, tx_b3, tx_b4, tx_en, wr_stb, frame_err, err_cnt, busy);
    end
    n_checks++;
    if (ctrl_out !== 32'h0) begin
      n_errors++; $display("FAIL reset_ctrl: ctrl_out=%h required 00000000", ctrl_out);
    end
    @(negedge clk_25m); rst = 1'b0;
    repeat (2) @(posedge clk_25m);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx_en !== 1'b0 || err_cnt !== 8'h00) begin
      n_errors++; $display("FAIL post_reset_idle: busy=%b tx_en=%b err_cnt=%h required 0 0 00", busy, tx_en, err_cnt);
    end
    model_reset();
    $display("test_reset: done");
  endtask

  // Vectors with literal expected replies
  task automatic test_directed();
    logic [39:0] fr [6] = '{40'hA5_00_01_3C_E2, 40'hA5_00_02_00_A7, 40'hA5_00_03_00_A8,
                            40'hA5_00_01_3C_E3, 40'h00_00_01_3C_3D, 40'hA5_07_01_00_AD};
    logic [31:0] ex [6] = '{32'h5A_00_3C_96, 32'h5A_00_3C_96, 32'h5A_00_10_6A,
                            32'h5A_01_00_5B, 32'h0, 32'h5A_03_00_5D};
    int ex_tx   [6] = '{1, 1, 1, 1, 0, 1};
    int ex_wr   [6] = '{1, 0, 0, 0, 0, 0};
    int ex_ferr [6] = '{0, 0, 0, 1, 1, 1};
    int ex_cnt  [6] = '{0, 0, 0, 1, 2, 3};
    bit d, w; logic [7:0] st, dat;
    for (int i = 0; i < 6; i++) begin
      logic [39:0] f;
      f = fr[i];
      run_frame(f[39:32], f[31:24], f[23:16], f[15:8], f[7:0], -1, -1, 0);
      model_frame(f[39:32], f[31:24], f[23:16], f[15:8], f[7:0], d, st, dat, w);
      n_checks++;
      if (cap_tx_cnt != ex_tx[i] || (ex_tx[i] == 1 && (cap_tx_k != 2 || cap_tx !== ex[i]))) begin
        n_errors++;
        $display("FAIL dir%0d_reply: tx_cnt=%0d k=%0d bytes=%h, required cnt=%0d k=2 bytes=%h",
                 i, cap_tx_cnt, cap_tx_k, cap_tx, ex_tx[i], ex[i]);
      end
      n_checks++;
      if (cap_wr_cnt != ex_wr[i] || (ex_wr[i] == 1 && cap_wr_k != 2)) begin
        n_errors++;
        $display("FAIL dir%0d_wr_stb: count=%0d k=%0d, required count=%0d k=2", i, cap_wr_cnt, cap_wr_k, ex_wr[i]);
      end
      n_checks++;
      if (cap_ferr_cnt != ex_ferr[i] || (ex_ferr[i] == 1 && cap_ferr_k != 1) || err_cnt !== 8'(ex_cnt[i])) begin
        n_errors++;
        $display("FAIL dir%0d_err: frame_err count=%0d k=%0d err_cnt=%0d, required count=%0d k=1 err_cnt=%0d",
                 i, cap_ferr_cnt, cap_ferr_k, err_cnt, ex_ferr[i], ex_cnt[i]);
      end
      n_checks++;
      if (ctrl_out !== 32'h0000_003C) begin
        n_errors++; $display("FAIL dir%0d_ctrl: ctrl_out=%h required 0000003c", i, ctrl_out);
      end
      $display("directed %0d: frame=%h tx=%h wr=%0d ferr=%0d err_cnt=%0d", i, f, cap_tx, cap_wr_cnt, cap_ferr_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b1, b2, b3, b4, b5, st, dat;
      bit d, w;
      b1 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
      b2 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      b3 = 8'($urandom_range(0, 4));
      b4 = 8'($urandom);
      b5 = 8'((int'(b1) + int'(b2) + int'(b3) + int'(b4)) % 256);
      if ($urandom_range(0, 7) == 0) b5 = b5 + 8'($urandom_range(1, 255));
      run_frame(b1, b2, b3, b4, b5, -1, -1, 0);
      model_frame(b1, b2, b3, b4, b5, d, st, dat, w);
      n_checks++;
      if (d) begin
        if (cap_tx_cnt != 0) begin
          n_errors++; $display("FAIL rnd%0d_drop_tx: tx_en count=%0d required 0", i, cap_tx_cnt);
        end
      end else if (cap_tx_cnt != 1 || cap_tx_k != 2 || cap_tx !== model_reply(st, dat)) begin
        n_errors++;
        $display("FAIL rnd%0d_reply: cnt=%0d k=%0d bytes=%h, required 1 k=2 bytes=%h",
                 i, cap_tx_cnt, cap_tx_k, cap_tx, model_reply(st, dat));
      end
      n_checks++;
      if (cap_wr_cnt != int'(w) || ctrl_out !== model_ctrl()) begin
        n_errors++;
        $display("FAIL rnd%0d_write: wr_cnt=%0d ctrl=%h, required wr_cnt=%0d ctrl=%h",
                 i, cap_wr_cnt, ctrl_out, w, model_ctrl());
      end
      n_checks++;
      if (cap_ferr_cnt != ((d || st != 8'h00) ? 1 : 0) || err_cnt !== 8'(m_err)) begin
        n_errors++;
        $display("FAIL rnd%0d_err: frame_err count=%0d err_cnt=%0d, required count=%0d err_cnt=%0d",
                 i, cap_ferr_cnt, err_cnt, (d || st != 8'h00) ? 1 : 0, m_err);
      end
      $display("random %0d: frame=%h%h%h%h%h tx=%h ctrl=%h err_cnt=%0d", i, b1, b2, b3, b4, b5, cap_tx, ctrl_out, err_cnt);
    end
  endtask

  // Second edge in GAP, and in the last GAP cycle; busy timing from tx_en
  task automatic test_back_to_back();
    int inj [2] = '{7, 17};
    for (int i = 0; i < 2; i++) begin
      bit d, w; logic [7:0] st, dat;
      run_frame(8'hA5, 8'h01, 8'h03, 8'h00, 8'hA9, inj[i], -1, 0);
      model_frame(8'hA5, 8'h01, 8'h03, 8'h00, 8'hA9, d, st, dat, w);
      model_err();
      n_checks++;
      if (cap_tx_cnt != 1 || cap_tx_k != 2 || cap_tx !== 32'h5A_00_10_6A) begin
        n_errors++; $display("FAIL gap%0d_tx: count=%0d k=%0d bytes=%h required 1 k=2 5a00106a", i, cap_tx_cnt, cap_tx_k, cap_tx);
      end
      n_checks++;
      if (cap_ferr_cnt != 1 || cap_ferr_k != inj[i] + 1 || err_cnt !== 8'(m_err)) begin
        n_errors++;
        $display("FAIL gap%0d_drop: frame_err count=%0d k=%0d err_cnt=%0d required 1 k=%0d err_cnt=%0d",
                 i, cap_ferr_cnt, cap_ferr_k, err_cnt, inj[i] + 1, m_err);
      end
      n_checks++;
      if (cap_busy_last != 2 + GAP - 1) begin
        n_errors++; $display("FAIL gap%0d_busy: last busy k=%0d required %0d", i, cap_busy_last, 2 + GAP - 1);
      end
      $display("back_to_back %0d: inj_k=%0d tx_cnt=%0d ferr_k=%0d busy_last=%0d", i, inj[i], cap_tx_cnt, cap_ferr_k, cap_busy_last);
    end
  endtask

  task automatic test_held_high();
    bit d, w; logic [7:0] st, dat;
    run_frame(8'hA5, 8'h03, 8'h01, 8'h5C, 8'h05, -1, -1, 1);
    model_frame(8'hA5, 8'h03, 8'h01, 8'h5C, 8'h05, d, st, dat, w);
    n_checks++;
    if (cap_tx_cnt != 1 || cap_ferr_cnt != 0 || ctrl_out !== model_ctrl()) begin
      n_errors++;
      $display("FAIL held_high: tx_cnt=%0d ferr=%0d ctrl=%h required 1 0 %h", cap_tx_cnt, cap_ferr_cnt, ctrl_out, model_ctrl());
    end
    rx_rdy = 1'b0;
    $display("held_high: tx_cnt=%0d ctrl=%h", cap_tx_cnt, ctrl_out);
  endtask

  task automatic test_rst_mid();
    bit d, w; logic [7:0] st, dat;
    run_frame(8'hA5, 8'h02, 8'h01, 8'h77, 8'h1F, -1, 1, 0);
    model_reset();
    n_checks++;
    if (cap_tx_cnt != 0 || cap_wr_cnt != 0 || ctrl_out !== 32'h0 || err_cnt !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid: tx_cnt=%0d wr_cnt=%0d ctrl=%h err_cnt=%0d required 0 0 00000000 0",
               cap_tx_cnt, cap_wr_cnt, ctrl_out, err_cnt);
    end
    run_frame(8'hA5, 8'h02, 8'h01, 8'h77, 8'h1F, -1, -1, 0);
    model_frame(8'hA5, 8'h02, 8'h01, 8'h77, 8'h1F, d, st, dat, w);
    n_checks++;
    if (cap_tx_cnt != 1 || cap_tx !== model_reply(st, dat) || cap_wr_cnt != 1 || ctrl_out !== model_ctrl()) begin
      n_errors++;
      $display("FAIL rst_recover: tx=%h wr_cnt=%0d ctrl=%h required tx=%h wr_cnt=1 ctrl=%h",
               cap_tx, cap_wr_cnt, ctrl_out, model_reply(st, dat), model_ctrl());
    end
    $display("rst_mid: recovered tx=%h ctrl=%h", cap_tx, ctrl_out);
  endtask

  task automatic test_err_saturate();
    bit d, w; logic [7:0] st, dat;
    for (int i = 0; i < 260; i++) begin
      run_frame(8'h00, 8'h00, 8'h01, 8'h00, 8'h01, -1, -1, 0);
      model_frame(8'h00, 8'h00, 8'h01, 8'h00, 8'h01, d, st, dat, w);
    end
    n_checks++;
    if (err_cnt !== 8'(m_err) || cap_ferr_cnt != 1) begin
      n_errors++;
      $display("FAIL err_saturate: err_cnt=%0d last frame_err count=%0d required %0d and 1", err_cnt, cap_ferr_cnt, m_err);
    end
    $display("err_saturate: err_cnt=%0d", err_cnt);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_held_high();
    test_rst_mid();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
